// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM state encoding and the BCD counter limits.
package stopwatch_pkg;

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] BCD_MAX = 24'h595999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_rise_detect.sv
// One-flop rising-edge detector for a debounced button level.
// The history flop tracks the level even during reset.
module rise_detect (
    input  logic i_clk,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button FSM, 10 ms tick prescaler,
// counter init/latch control, lap capture and overflow flag.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic             i_rtcclk,
    input  logic             i_reset_n,
    input  logic             i_startstop,
    input  logic             i_lapreset,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_countenb,
    output logic             o_countinit,
    output logic             o_latchcount,
    output logic [CNT_W-1:0] o_lap,
    output logic [1:0]       o_state,
    output logic             o_ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic             r_countenb;
    logic             r_countinit;
    logic             r_latch;
    logic [CNT_W-1:0] r_lap;
    logic             r_ovf;

    logic             w_ss_rise;
    logic             w_lp_rise;
    logic             w_lap_edge;
    state_t           w_next;
    logic             w_latch_n;
    logic [CNT_W-1:0] w_lap_n;
    logic             w_init_n;
    logic             w_clr;
    logic             w_counting;
    logic             w_wrap;
    logic [PW-1:0]    w_presc_n;
    logic             w_en_n;

    rise_detect u_ss_rise (
        .i_clk   (i_rtcclk),
        .i_level (i_startstop),
        .o_rise  (w_ss_rise)
    );

    rise_detect u_lp_rise (
        .i_clk   (i_rtcclk),
        .i_level (i_lapreset),
        .o_rise  (w_lp_rise)
    );

    // Start/stop has priority; a coincident lap edge is dropped.
    assign w_lap_edge = w_lp_rise & ~w_ss_rise;

    always_comb begin
        w_next    = r_state;
        w_latch_n = r_latch;
        w_lap_n   = r_lap;
        w_init_n  = 1'b0;
        w_clr     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ss_rise) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ss_rise) begin
                    w_next = ST_STOP;
                end else if (w_lap_edge) begin
                    w_next    = ST_LAP;
                    w_lap_n   = i_count;
                    w_latch_n = 1'b0;
                end
            end
            ST_LAP: begin
                if (w_ss_rise) begin
                    w_next    = ST_STOP;
                    w_latch_n = 1'b1;
                end else if (w_lap_edge) begin
                    w_next    = ST_RUN;
                    w_latch_n = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_ss_rise) begin
                    w_next = ST_RUN;
                end else if (w_lap_edge) begin
                    w_next   = ST_IDLE;
                    w_init_n = 1'b1;
                    w_lap_n  = '0;
                    w_clr    = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Prescaler runs in RUN/LAP, holds in STOP so resume keeps phase.
    always_comb begin
        w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
        w_wrap     = w_counting && (r_presc == PMAX);
        w_presc_n  = r_presc;
        if (r_state == ST_IDLE) begin
            w_presc_n = '0;
        end else if (w_wrap) begin
            w_presc_n = '0;
        end else if (w_counting) begin
            w_presc_n = r_presc + PW'(1);
        end
        w_en_n = w_wrap && (w_next != ST_STOP);
    end

    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_countenb  <= 1'b0;
            r_countinit <= 1'b0;
            r_latch     <= 1'b1;
            r_lap       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_presc     <= w_presc_n;
            r_countenb  <= w_en_n;
            r_countinit <= w_init_n;
            r_latch     <= w_latch_n;
            r_lap       <= w_lap_n;
            if (w_clr) begin
                r_ovf <= 1'b0;
            end else if (r_countenb && (i_count == BCD_MAX)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_countenb   = r_countenb;
    assign o_countinit  = r_countinit;
    assign o_latchcount = r_latch;
    assign o_lap        = r_lap;
    assign o_state      = r_state;
    assign o_ovf        = r_ovf;

endmodule
